uart_rx_8n1: RTL and testbench
==============================

# uart_rx_8n1

UART receiver for 8 data bits, no parity, 1 stop bit (8N1). It is the receive counterpart of the design's 8N1 transmitter and uses the same `CLOCK_FREQ`/`BAUD_RATE` parameterisation. It samples the asynchronous `rx` pad line at 16x oversampling, validates the start bit, and reads the data LSB-first at mid-bit. Each byte is presented with a one-cycle strobe; a bad stop bit raises a framing-error strobe. The whole block runs in the single `clk` domain: oversample ticks are clock enables, never clocks.

## Interface
Parameters:
- `CLOCK_FREQ`, 50000000: system clock frequency, Hz.
- `BAUD_RATE`, 9600: line baud rate.
- `OVERSAMPLE`, 16: ticks per bit. Must be even and ≥ 4.

Ports:
- `clk`  in  1: system clock. One clock domain only.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `rx`  in  1: serial line, asynchronous to `clk`, idles high.
- `rxbyte`  out  8: last correctly framed byte. Holds its value until the next good frame.
- `rxdone`  out  1: one-cycle pulse when `rxbyte` updates.
- `rxerror`  out  1: one-cycle pulse on a framing error (stop bit sampled 0).
- `rxbusy`  out  1: high while in START, DATA or STOP.

## Operation
- **Divider:** `DIV = CLOCK_FREQ / (BAUD_RATE*OVERSAMPLE)`, integer division, truncated. `DIV < 1` is an elaboration error.
- **Tick counter:** counts 0..DIV-1 and emits a one-cycle tick enable on wrap. It is cleared on start detection.
- **Synchroniser:** 2-flop chain on `rx`, reset to 1. All logic uses only the synchronised value `rx_s`.
- **Counters:**
  - `os_cnt`: 4 bits, counts ticks within a bit.
  - `bit_cnt`: 3 bits.
  - Shift register: 8 bits, shifts right, new bit enters at bit 7.
- **States:**
  - IDLE: `rx_s`==0 → START. Clear the tick counter and `os_cnt`.
  - START: after OVERSAMPLE/2 ticks, sample `rx_s`. If 0 → DATA with `os_cnt`=0 and `bit_cnt`=0. If 1 it was a false start → IDLE.
  - DATA: every OVERSAMPLE ticks, shift in `rx_s`. After the bit with `bit_cnt`==7 → STOP; otherwise increment `bit_cnt`.
  - STOP: after OVERSAMPLE ticks, sample `rx_s`.
    - If 1: load `rxbyte` from the shift register, pulse `rxdone`, go to IDLE.
    - If 0: pulse `rxerror`, leave `rxbyte` unchanged, go to BREAK.
  - BREAK: wait for `rx_s`==1, then → IDLE. This prevents a held-low line (break) from retriggering.
- **Sampling and back-to-back frames:** every sample is taken at mid-bit. The return to IDLE therefore happens half a bit early, so a following start edge with no idle gap is still detected.
- **Reset:** asynchronous reset at any time, including mid-frame:
  - state → IDLE;
  - all counters and the shift register → 0;
  - `rxbyte` = 0x00, `rxdone` = 0, `rxerror` = 0, `rxbusy` = 0;
  - synchroniser flops → 1.
  
  The partial frame is discarded with no strobe.
- **No overrun flag:** consumers must take `rxbyte` within one frame time of `rxdone` (≥ 10 bit periods).

## Timing
- Edge numbering: the pad falls before clock edge E0. `rx_s` reads low at E2 (synchroniser latency 2). Detection happens at E2.
- With DIV=d and OVERSAMPLE=16:
  - start check at E2+8d;
  - data bit i sampled at E2+8d+16d(i+1);
  - stop bit sampled at E2+152d.
- `rxdone` or `rxerror` is high in the single cycle after the stop-sample edge. `rxbyte` is valid in that same cycle.
- `rxbusy` goes high the cycle after detection and low in the same cycle as `rxdone`/`rxerror`.
- Tolerance: a frame must be received correctly with ±3% baud mismatch at OVERSAMPLE=16.

## Structure
- Shared package `uart_pkg`:
  - state encoding localparams (IDLE, START, DATA, STOP, BREAK; 3 bits);
  - `OVERSAMPLE` default;
  - `DIV` computation function, reused by the transmitter.
- One sub-module: `uart_oversample_tick`.
  - Ports: `clk`, `rst_n`, `clear`, `tick`.
  - Parameter: `DIV`.
  - Output is a clock-enable pulse only.
- The FSM, synchroniser and shift register live in `uart_rx_8n1`.

## Test plan
All scenarios use CLOCK_FREQ=1600000, BAUD_RATE=100000 (DIV=1, 16 clk/bit).
- **Single byte:** frame 0xA5 → `rxbyte`=0xA5 with a single `rxdone` pulse in the cycle after E154 (E0 = pad fall); `rxerror` stays 0.
- **Back-to-back frames:** 0x00 then 0xFF, no idle gap → two `rxdone` pulses 160 cycles apart, values 0x00 then 0xFF.
- **Glitch:** `rx` low for 4 clk → `rxbusy` drops by E11; no `rxdone` or `rxerror`; next 0x3C frame received correctly.
- **Framing error:** 0x3C with the stop bit driven 0, line then held low for 200 clk → one `rxerror` pulse; `rxbyte` keeps its previous value; no further activity until `rx` rises; the following 0x81 frame is received correctly.
- **Reset mid-frame:** `rst_n` asserted during bit 3 → all outputs 0 immediately; a subsequent 0x5A frame gives `rxbyte`=0x5A.
- **Baud mismatch:** frames 0xC3 sent at 15 and 17 clk/bit → both received as 0xC3, no `rxerror`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversample default and baud divider.
package uart_pkg;

    localparam int unsigned OVERSAMPLE_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_e;

    // Clock cycles per oversample tick, truncated; zero means the baud rate is unreachable.
    function automatic int unsigned calc_div(input int unsigned clock_freq,
                                             input int unsigned baud_rate,
                                             input int unsigned oversample);
        return clock_freq / (baud_rate * oversample);
    endfunction

endpackage

// File: rtl/uart_oversample_tick.sv
// Free-running divider producing a one-cycle clock-enable every DIV clocks.
module uart_oversample_tick #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || (cnt_q == CntLast)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CntLast);

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-flop synchroniser, oversampled start validation, mid-bit sampling.
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 50000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rxbyte,
    output logic       rxdone,
    output logic       rxerror,
    output logic       rxbusy
);

    localparam int unsigned DIV = calc_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned OsW = $clog2(OVERSAMPLE);
    localparam logic [OsW-1:0] OsHalf = OsW'(OVERSAMPLE / 2 - 1);
    localparam logic [OsW-1:0] OsLast = OsW'(OVERSAMPLE - 1);

    if (DIV == 0) begin : g_bad_div
        $error("uart_rx_8n1: CLOCK_FREQ too low for BAUD_RATE*OVERSAMPLE");
    end
    if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
        $error("uart_rx_8n1: OVERSAMPLE must be even and at least 4");
    end

    logic rx_meta, rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    rx_state_e       state_q, state_d;
    logic [OsW-1:0]  os_cnt_q, os_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      rxbyte_q, rxbyte_d;
    logic            rxdone_q, rxdone_d;
    logic            rxerror_q, rxerror_d;
    logic            tick;
    logic            tick_clear;

    uart_oversample_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (tick_clear),
        .tick  (tick)
    );

    always_comb begin
        state_d    = state_q;
        os_cnt_d   = os_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rxbyte_d   = rxbyte_q;
        rxdone_d   = 1'b0;
        rxerror_d  = 1'b0;
        tick_clear = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Realign the tick phase to the start edge.
                if (!rx_s) begin
                    state_d    = START;
                    os_cnt_d   = '0;
                    tick_clear = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (os_cnt_q == OsHalf) begin
                        os_cnt_d  = '0;
                        bit_cnt_d = '0;
                        state_d   = rx_s ? IDLE : DATA;
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (os_cnt_q == OsLast) begin
                        os_cnt_d = '0;
                        shift_d  = {rx_s, shift_q[7:1]};
                        if (bit_cnt_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (os_cnt_q == OsLast) begin
                        os_cnt_d = '0;
                        if (rx_s) begin
                            rxbyte_d = shift_q;
                            rxdone_d = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            rxerror_d = 1'b1;
                            state_d   = BREAK;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
            end
            BREAK: begin
                // A held-low line must rise before another start is accepted.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            os_cnt_q  <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            rxbyte_q  <= '0;
            rxdone_q  <= 1'b0;
            rxerror_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            os_cnt_q  <= os_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            rxbyte_q  <= rxbyte_d;
            rxdone_q  <= rxdone_d;
            rxerror_q <= rxerror_d;
        end
    end

    assign rxbyte  = rxbyte_q;
    assign rxdone  = rxdone_q;
    assign rxerror = rxerror_q;
    assign rxbusy  = (state_q == START) || (state_q == DATA) || (state_q == STOP);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Scoreboard bench for uart_rx_8n1 at DIV=1 (16 clk per bit).
module tb_uart_rx_8n1;

    localparam int StopLat = 154;  // pad fall to strobe-visible cycle at 16 clk/bit

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] rxbyte;
    logic       rxdone;
    logic       rxerror;
    logic       rxbusy;

    uart_rx_8n1 #(
        .CLOCK_FREQ (1600000),
        .BAUD_RATE  (100000),
        .OVERSAMPLE (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (rx),
        .rxbyte  (rxbyte),
        .rxdone  (rxdone),
        .rxerror (rxerror),
        .rxbusy  (rxbusy)
    );

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic [7:0] last_good = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cyc %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Model: a frame with stop=1 yields its byte; stop=0 yields an error with rxbyte held.
    task automatic send(input logic [7:0] data, input logic stop, input int cpb);
        logic [9:0] bits;
        exp_t       e;
        bits   = {stop, data, 1'b0};
        e.err  = !stop;
        e.data = stop ? data : last_good;
        e.cyc  = (cpb == 16) ? cyc + 1 + StopLat : -1;
        if (stop) last_good = data;
        q.push_back(e);
        for (int b = 0; b < 10; b++) begin
            rx = bits[b];
            repeat (cpb) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rxdone === 1'b1 || rxerror === 1'b1) begin
                if (rxdone === 1'b1 && rxerror === 1'b1) begin
                    total = total + 1;
                    bad = bad + 1;
                    $display("FAIL both_strobes: got rxdone=1 rxerror=1 expected one at cyc %0d",
                             cyc);
                end
                if (q.size() == 0) begin
                    total = total + 1;
                    bad = bad + 1;
                    $display("FAIL unexpected_strobe: got rxdone=%0b rxerror=%0b expected none at cyc %0d",
                             rxdone, rxerror, cyc);
                end else begin
                    e = q.pop_front();
                    chk("strobe_is_error", int'(rxerror), int'(e.err));
                    chk("rxbyte", int'(rxbyte), int'(e.data));
                    if (e.cyc >= 0) chk("strobe_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        int e0;
        logic [7:0] d;
        logic       s;
        int         gap;

        rx    = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("reset_rxbyte", int'(rxbyte), 0);
        chk("reset_rxdone", int'(rxdone), 0);
        chk("reset_rxerror", int'(rxerror), 0);
        chk("reset_rxbusy", int'(rxbusy), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send(8'hA5, 1'b1, 16);
        idle(10);

        send(8'h00, 1'b1, 16);
        send(8'hFF, 1'b1, 16);
        idle(10);

        // Glitch: 4 clk low pulse must be rejected at the start check.
        e0 = cyc + 1;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        while (cyc < e0 + 5) @(negedge clk);
        chk("glitch_busy_high", int'(rxbusy), 1);
        while (cyc < e0 + 11) @(negedge clk);
        chk("glitch_busy_dropped", int'(rxbusy), 0);
        idle(20);
        send(8'h3C, 1'b1, 16);
        idle(10);

        // Framing error followed by a long break.
        send(8'h3C, 1'b0, 16);
        repeat (200) @(negedge clk);
        chk("break_not_busy", int'(rxbusy), 0);
        chk("break_rxbyte_held", int'(rxbyte), 8'h3C);
        idle(10);
        send(8'h81, 1'b1, 16);
        idle(10);

        // Reset during data bit 3 discards the frame.
        rx = 1'b0;
        repeat (72) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_rxbyte", int'(rxbyte), 0);
        chk("midreset_rxdone", int'(rxdone), 0);
        chk("midreset_rxerror", int'(rxerror), 0);
        chk("midreset_rxbusy", int'(rxbusy), 0);
        last_good = 8'h00;
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        send(8'h5A, 1'b1, 16);
        idle(10);

        send(8'hC3, 1'b1, 15);
        idle(40);
        send(8'hC3, 1'b1, 17);
        idle(40);

        for (int i = 0; i < 12; i++) begin
            d   = 8'($urandom);
            s   = ($urandom_range(0, 4) != 0);
            gap = s ? $urandom_range(0, 12) : $urandom_range(3, 12);
            send(d, s, 16);
            if (gap > 0) idle(gap);
        end
        idle(10);

        for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
